// File: rtl/keypad_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_ctrl
//
// Purpose
//   Scans a 4x4 matrix keypad through a 2-flop synchronizer, debounces
//   presses (and releases) with a four-state FSM, queues key events in a
//   small FIFO and presents them to the CPU as a memory-mapped read
//   device with a level interrupt.
//
// Parameters
//   DEBOUNCE_CYCLES  stable-input cycles before a press/release is accepted
//                    (must be >= 1).
//   FIFO_DEPTH       event FIFO entries; power of two in 2..16.
//
// Optional feature
//   KEYPAD_RELEASE_EN  when defined, finishing a release debounce pushes a
//                      release event (bit4 = 1). When undefined no release
//                      event is ever queued and bit4 of every event is 0.
//
// Ports
//   clk            system clock, all state updates on its rising edge
//   rst_n          asynchronous active-low reset
//   enable_i       device select
//   readEnable_i   read strobe qualifier (writes are ignored)
//   mode_i         register select: 0 = data (FIFO head), 1 = status
//   dataLoad_o     32-bit read data (0 when not selected)
//   int_o          registered interrupt, high while the FIFO holds events
//   btn_key_col_i  raw column lines, active-high, asynchronous
//   btn_key_row_i  raw row lines, active-high, asynchronous
//
// Register map
//   data   : bits[3:0] key code {row[1:0], col[1:0]}, bit4 release flag;
//            reads 32'h0000_0100 when the FIFO is empty.
//   status : bit0 empty, bit1 full, bit2 sticky overflow,
//            bits[8:4] entry count, bits[11:10] FSM state.
//
// Bus handshake: an access is the level (enable_i & readEnable_i). Its side
// effect (pop for data, overflow clear for status) happens once, on the
// rising edge that ends the first cycle of the access; holding the access
// for more cycles only keeps the combinational read data on the bus.
// ---------------------------------------------------------------------------
module keypad_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        readEnable_i,
  input  logic        mode_i,
  output logic [31:0] dataLoad_o,
  output logic        int_o,
  input  logic [3:0]  btn_key_col_i,
  input  logic [3:0]  btn_key_row_i
);

  // -------------------------------------------------------------------------
  // Derived sizes
  // -------------------------------------------------------------------------
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [31:0] EMPTY_WORD = 32'h0000_0100;

  // -------------------------------------------------------------------------
  // FSM encoding doubles as the status-register field, so keep it fixed.
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Only meaningful for one-hot inputs; the validity check gates its use.
  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // -------------------------------------------------------------------------
  // 2-flop synchronizers: the raw lines are asynchronous to clk and must not
  // reach any decode logic before the second stage.
  // -------------------------------------------------------------------------
  logic [3:0] col_meta_q, col_sync_q;
  logic [3:0] row_meta_q, row_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= 4'd0;
      col_sync_q <= 4'd0;
      row_meta_q <= 4'd0;
      row_sync_q <= 4'd0;
    end else begin
      col_meta_q <= btn_key_col_i;
      col_sync_q <= col_meta_q;
      row_meta_q <= btn_key_row_i;
      row_sync_q <= row_meta_q;
    end
  end

  // -------------------------------------------------------------------------
  // Sample classification
  //   valid    : exactly one row and exactly one column active
  //   released : no line active at all
  //   anything else (ghosting, multi-key) is invalid
  // -------------------------------------------------------------------------
  logic       sample_valid;
  logic       sample_released;
  logic [3:0] sample_code;

  always_comb begin
    sample_valid    = is_onehot4(col_sync_q) && is_onehot4(row_sync_q);
    sample_released = (col_sync_q == 4'd0) && (row_sync_q == 4'd0);
    sample_code     = {enc4(row_sync_q), enc4(col_sync_q)};
  end

  // -------------------------------------------------------------------------
  // Debounce FSM
  // -------------------------------------------------------------------------
  state_t         state_q, state_d;
  logic [DBW-1:0] cnt_q, cnt_d;
  logic [3:0]     cand_q, cand_d;
  logic           push;
  logic [4:0]     push_data;
  logic           sample_match;
  logic [DBW-1:0] cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cand_d       = cand_q;
    push         = 1'b0;
    push_data    = 5'd0;
    sample_match = sample_valid && (sample_code == cand_q);
    // Saturating increment; the FSM normally leaves before reaching DB_MAX.
    cnt_inc      = (cnt_q == DB_MAX) ? cnt_q : cnt_q + DBW'(1);

    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          state_d = ST_PRESS_DB;
          cand_d  = sample_code;
          cnt_d   = '0;
        end
      end

      ST_PRESS_DB: begin
        if (!sample_match) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          // This cycle is the DEBOUNCE_CYCLES-th consecutive match.
          state_d   = ST_HELD;
          cnt_d     = '0;
          push      = 1'b1;
          push_data = {1'b0, cand_q};
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_HELD: begin
        // Any deviation (release, ghost pattern, another key) starts a
        // release debounce; only real "released" samples can finish it.
        if (!sample_match) begin
          state_d = ST_REL_DB;
          cnt_d   = '0;
        end
      end

      ST_REL_DB: begin
        if (sample_match) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (sample_released) begin
          if (cnt_q >= DB_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
`ifdef KEYPAD_RELEASE_EN
            push      = 1'b1;
            push_data = {1'b1, cand_q};
`else
            push      = 1'b0;
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          // A different key or a ghost pattern means "not yet released":
          // the run of released samples must start over.
          cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Bus access edge detection (one side effect per access)
  // -------------------------------------------------------------------------
  logic rd_cond, st_cond;
  logic rd_prev_q, rd_prev_d;
  logic st_prev_q, st_prev_d;
  logic pop_req, st_first;

  always_comb begin
    rd_cond   = enable_i & readEnable_i & ~mode_i;
    st_cond   = enable_i & readEnable_i &  mode_i;
    pop_req   = rd_cond & ~rd_prev_q;
    st_first  = st_cond & ~st_prev_q;
    rd_prev_d = rd_cond;
    st_prev_d = st_cond;
  end

  // -------------------------------------------------------------------------
  // Event FIFO
  // -------------------------------------------------------------------------
  logic [4:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          int_q, int_d;
  logic          fifo_empty, fifo_full;
  logic          pop_en, wr_en;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_C);
    // A pop on an empty FIFO does nothing, even if a push lands this cycle.
    pop_en     = pop_req & ~fifo_empty;
    // A full FIFO still accepts a push when the same edge frees a slot.
    wr_en      = push & (~fifo_full | pop_en);

    // Pointers are AW bits wide, so the increment wraps modulo FIFO_DEPTH.
    wr_ptr_d = wr_en  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_en ? rd_ptr_q + AW'(1) : rd_ptr_q;

    case ({wr_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A dropped push wins over a same-cycle status clear so that the
    // loss is never hidden from software.
    if (push && !wr_en) begin
      ovf_d = 1'b1;
    end else if (st_first) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    int_d = ~fifo_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      int_q     <= 1'b0;
      rd_prev_q <= 1'b0;
      st_prev_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      int_q     <= int_d;
      rd_prev_q <= rd_prev_d;
      st_prev_q <= st_prev_d;
    end
  end

  // Storage is not reset; an entry is only visible once the count covers it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // -------------------------------------------------------------------------
  // Read data mux
  // -------------------------------------------------------------------------
  logic [31:0] status_word;
  logic [31:0] data_word;

  always_comb begin
    status_word = {20'd0, state_q, 1'b0, 5'(count_q), 1'b0,
                   ovf_q, fifo_full, fifo_empty};
    data_word   = fifo_empty ? EMPTY_WORD : {27'd0, mem_q[rd_ptr_q]};

    dataLoad_o = 32'd0;
    if (enable_i && readEnable_i) begin
      dataLoad_o = mode_i ? status_word : data_word;
    end
  end

  assign int_o = int_q;

endmodule

// File: tb/tb_keypad_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keypad_ctrl
//
// Directed bench for keypad_ctrl with DEBOUNCE_CYCLES = 8, FIFO_DEPTH = 4.
// Builds with or without KEYPAD_RELEASE_EN; release-dependent expectations
// are selected through the REL constant.
//
// Timing reference used throughout: inputs change just after a falling
// edge. A key driven there is seen by the FSM two rising edges later (sync),
// enters PRESS_DB on the 3rd edge and completes on the 11th edge
// (8 matching cycles), so the event is queued after 11 rising edges.
// ---------------------------------------------------------------------------
module tb_keypad_ctrl;

  localparam int DB    = 8;
  localparam int DEPTH = 4;

`ifdef KEYPAD_RELEASE_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic        readEnable_i;
  logic        mode_i;
  logic [31:0] dataLoad_o;
  logic        int_o;
  logic [3:0]  btn_key_col_i;
  logic [3:0]  btn_key_row_i;

  always #5 clk = ~clk;

  keypad_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable_i),
    .readEnable_i  (readEnable_i),
    .mode_i        (mode_i),
    .dataLoad_o    (dataLoad_o),
    .int_o         (int_o),
    .btn_key_col_i (btn_key_col_i),
    .btn_key_row_i (btn_key_row_i)
  );

  // -------------------------------------------------------------------------
  // Scoreboard counters and comparison
  // -------------------------------------------------------------------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic check32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input logic exp);
    check32(tag, {31'd0, int_o}, {31'd0, exp});
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input logic [3:0] row, input logic [3:0] col);
    btn_key_row_i = row;
    btn_key_col_i = col;
  endtask

  task automatic bus_idle();
    enable_i     = 1'b0;
    readEnable_i = 1'b0;
    mode_i       = 1'b0;
  endtask

  // Status look without crossing a rising edge: no side effect.
  task automatic peek_status(input string tag, input logic [31:0] exp);
    enable_i     = 1'b1;
    readEnable_i = 1'b1;
    mode_i       = 1'b1;
    #1;
    check32(tag, dataLoad_o, exp);
    bus_idle();
  endtask

  // Full status access: held across one rising edge (clears overflow).
  task automatic read_status(input string tag, input logic [31:0] exp);
    enable_i     = 1'b1;
    readEnable_i = 1'b1;
    mode_i       = 1'b1;
    #1;
    check32(tag, dataLoad_o, exp);
    tick(1);
    bus_idle();
    tick(1);
  endtask

  // Full data access: held across one rising edge (pops if non-empty).
  task automatic read_data(input string tag, input logic [31:0] exp);
    enable_i     = 1'b1;
    readEnable_i = 1'b1;
    mode_i       = 1'b0;
    #1;
    check32(tag, dataLoad_o, exp);
    tick(1);
    bus_idle();
    tick(1);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  logic [3:0]  k_row [5];
  logic [3:0]  k_col [5];
  logic [31:0] q_exp [4];

  initial begin
    k_row = '{4'b0001, 4'b0001, 4'b0010, 4'b1000, 4'b0100};
    k_col = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    // Codes 0,1,6,F,8. With release events enabled each key yields press
    // then release, so only the first two keys fit in the FIFO.
    if (REL) q_exp = '{32'h00, 32'h10, 32'h01, 32'h11};
    else     q_exp = '{32'h00, 32'h01, 32'h06, 32'h0F};

    rst_n = 1'b0;
    bus_idle();
    set_key(4'd0, 4'd0);
    tick(2);

    // ---- reset state ----
    check_int("rst_int", 1'b0);
    peek_status("rst_status", 32'h001);
    rst_n = 1'b1;
    tick(2);
    read_data("rst_empty_read", 32'h100);
    check32("rst_disabled_zero", dataLoad_o, 32'h0);

    // ---- scenario 1: row2/col1 held 20 cycles -> one 0x09 event ----
    set_key(4'b0100, 4'b0010);
    tick(20);
    check_int("s1_int_high", 1'b1);
    peek_status("s1_status", 32'h810);
    enable_i     = 1'b0;
    readEnable_i = 1'b1;
    #1;
    check32("s1_enable_low", dataLoad_o, 32'h0);
    bus_idle();
    enable_i     = 1'b1;
    readEnable_i = 1'b1;
    #1;
    check32("s1_event", dataLoad_o, 32'h09);
    tick(1);
    check_int("s1_int_lag", 1'b1);
    bus_idle();
    tick(1);
    check_int("s1_int_low", 1'b0);
    set_key(4'd0, 4'd0);
    tick(14);
    read_data("s1_release", REL ? 32'h19 : 32'h100);
    peek_status("s1_idle", 32'h001);

    // ---- scenario 5: two columns at once -> nothing ----
    set_key(4'b0001, 4'b0011);
    tick(20);
    peek_status("s5_invalid_idle", 32'h001);
    set_key(4'd0, 4'd0);
    tick(4);

    // ---- reset in the middle of a press debounce ----
    set_key(4'b0010, 4'b0010);
    tick(6);
    peek_status("rstdb_pressdb", 32'h401);
    rst_n = 1'b0;
    #1;
    peek_status("rstdb_in_reset", 32'h001);
    set_key(4'd0, 4'd0);
    tick(2);
    rst_n = 1'b1;
    tick(20);
    peek_status("rstdb_no_event", 32'h001);
    check_int("rstdb_int", 1'b0);

    // ---- scenario 2: bounce every 5 cycles, then stable ----
    for (int i = 0; i < 4; i++) begin
      set_key(4'b0100, 4'b0010);
      tick(5);
      set_key(4'd0, 4'd0);
      tick(5);
    end
    peek_status("s2_bounce_none", 32'h001);
    set_key(4'b0100, 4'b0010);
    tick(10);
    peek_status("s2_before", 32'h401);
    tick(1);
    peek_status("s2_pushed", 32'h810);
    check_int("s2_int_lag", 1'b0);
    tick(1);
    check_int("s2_int_high", 1'b1);
    tick(20);
    peek_status("s2_single", 32'h810);
    read_data("s2_event", 32'h09);
    set_key(4'd0, 4'd0);
    tick(14);
    read_data("s2_release", REL ? 32'h19 : 32'h100);

    // ---- scenario 3: five keys, no reads -> full + overflow ----
    for (int k = 0; k < 5; k++) begin
      set_key(k_row[k], k_col[k]);
      tick(14);
      set_key(4'd0, 4'd0);
      tick(14);
    end
    read_status("s3_ovf_set", 32'h046);
    read_status("s3_ovf_clear", 32'h042);

    // ---- push and pop on the same edge while full ----
    set_key(4'b0010, 4'b0010);
    tick(10);
    enable_i     = 1'b1;
    readEnable_i = 1'b1;
    #1;
    check32("full_pp_head", dataLoad_o, q_exp[0]);
    tick(1);
    bus_idle();
    tick(1);
    peek_status("full_pp_status", 32'h842);
    set_key(4'd0, 4'd0);
    tick(14);
    peek_status("full_pp_release", REL ? 32'h046 : 32'h042);

    // ---- scenario 4: drain to two, then one access held 3 cycles ----
    read_data("s4_q1", q_exp[1]);
    read_data("s4_q2", q_exp[2]);
    enable_i     = 1'b1;
    readEnable_i = 1'b1;
    #1;
    check32("s4_held_head", dataLoad_o, q_exp[3]);
    tick(3);
    bus_idle();
    tick(1);
    peek_status("s4_one_pop", REL ? 32'h014 : 32'h010);
    read_data("s4_last", 32'h05);
    read_data("s4_empty", 32'h100);
    read_status("s4_status", REL ? 32'h005 : 32'h001);

    // ---- push and pop on the same edge while empty ----
    set_key(4'b1000, 4'b0001);
    tick(10);
    enable_i     = 1'b1;
    readEnable_i = 1'b1;
    #1;
    check32("empty_pp_read", dataLoad_o, 32'h100);
    tick(1);
    bus_idle();
    tick(1);
    peek_status("empty_pp_status", 32'h810);
    read_data("empty_pp_event", 32'h0C);
    set_key(4'd0, 4'd0);
    tick(14);
    read_data("empty_pp_release", REL ? 32'h1C : 32'h100);

    // ---- scenario 6: key 0 press and release ----
    set_key(4'b0001, 4'b0001);
    tick(14);
    read_data("s6_press", 32'h00);
    set_key(4'd0, 4'd0);
    tick(14);
    read_data("s6_release", REL ? 32'h10 : 32'h100);
    peek_status("s6_idle", 32'h001);
    tick(2);
    check_int("s6_int", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
